// File: rtl/u_processor.sv
`default_nettype none
// ============================================================================
// Module   : u_processor
// Brief    : 16-bit microprogrammed register/accumulator processor with a
//            256-entry microcode ROM and a hit-handshaked memory port.
// Revision : 1.0 - initial release
// ============================================================================
module u_processor #(
    parameter int DATA_W  = 16,
    parameter int UADDR_W = 8,
    parameter int CTRL_W  = 39
) (
    input  logic               clk_100,
    input  logic               rst,
    input  logic [DATA_W-1:0]  memory_in,
    input  logic               hit,
    output logic               memory_write_en,
    output logic [CTRL_W-1:0]  control_signals,
    output logic [DATA_W-1:0]  instruction,
    output logic [UADDR_W-1:0] mux8,
    output logic [DATA_W-1:0]  b_bus,
    output logic [DATA_W-1:0]  c_bus,
    output logic [DATA_W-1:0]  acc,
    output logic [DATA_W-1:0]  tester,
    output logic [DATA_W-1:0]  address_out,
    output logic [DATA_W-1:0]  memory_out
);

    localparam logic [UADDR_W-1:0] C_FETCH1 = 8'h00, C_FETCH2 = 8'h01, C_DECODE = 8'h02,
                                   C_MOV    = 8'h08, C_ADD1   = 8'h10, C_ADD2   = 8'h11,
                                   C_SUB1   = 8'h18, C_SUB2   = 8'h19, C_AND1   = 8'h20,
                                   C_AND2   = 8'h21, C_OR1    = 8'h28, C_OR2    = 8'h29,
                                   C_LDI1   = 8'h30, C_LDI2   = 8'h31, C_ST1    = 8'h38,
                                   C_ST2    = 8'h39, C_ST3    = 8'h3A, C_JMP    = 8'h40,
                                   C_JZ1    = 8'h48, C_JZ_NO  = 8'h49, C_JZ_YES = 8'h4A,
                                   C_LD1    = 8'hE0, C_LD2    = 8'hE1, C_LD3    = 8'hE2,
                                   C_HALT   = 8'hF8;

    localparam logic [3:0] C_B_PC = 4'd0, C_B_AR = 4'd1, C_B_DR = 4'd2, C_B_IR = 4'd3,
                           C_B_AC = 4'd4, C_B_RD = 4'd5, C_B_RS = 4'd6, C_B_MEM = 4'd7;

    localparam logic [2:0] C_ALU_PASS = 3'd0, C_ALU_ADD = 3'd1, C_ALU_SUB = 3'd2,
                           C_ALU_AND  = 3'd3, C_ALU_OR  = 3'd4, C_ALU_INC = 3'd5;

    localparam logic [19:0] C_EN_NONE = 20'h00000, C_EN_PC = 20'h00001, C_EN_AR = 20'h00002,
                            C_EN_DR   = 20'h00004, C_EN_IR = 20'h00008, C_EN_AC = 20'h00010,
                            C_EN_RD   = 20'h00020, C_EN_PCINC = 20'h00040;

    function automatic logic [CTRL_W-1:0] uword(
        input logic [UADDR_W-1:0] nxt,
        input logic               dbr,
        input logic               zbr,
        input logic               mrd,
        input logic               mwr,
        input logic [3:0]         bsel,
        input logic [2:0]         op,
        input logic [19:0]        en
    );
        return {nxt, dbr, zbr, mrd, mwr, bsel, op, en};
    endfunction

    logic [UADDR_W-1:0] r_upc_q, w_upc_d;
    logic [DATA_W-1:0]  r_pc_q, w_pc_d, r_ar_q, w_ar_d, r_dr_q, w_dr_d;
    logic [DATA_W-1:0]  r_ir_q, w_ir_d, r_ac_q, w_ac_d;
    logic [DATA_W-1:0]  r_regs_q [16];
    logic [DATA_W-1:0]  w_regs_d [16];

    logic [CTRL_W-1:0]  w_ctrl;
    logic [UADDR_W-1:0] w_mux;
    logic [DATA_W-1:0]  w_b_bus, w_c_bus, w_alu_a;
    logic               w_stall;

    wire logic [4:0] w_opcode = r_ir_q[15:11];
    wire logic [3:0] w_rd     = r_ir_q[7:4];
    wire logic [3:0] w_rs     = r_ir_q[3:0];

    wire logic [UADDR_W-1:0] w_next = w_ctrl[38:31];
    wire logic       w_dbr   = w_ctrl[30];
    wire logic       w_zbr   = w_ctrl[29];
    wire logic       w_mrd   = w_ctrl[28];
    wire logic       w_mwr   = w_ctrl[27];
    wire logic [3:0] w_bsel  = w_ctrl[26:23];
    wire logic [2:0] w_aluop = w_ctrl[22:20];

    // Microcode ROM; unlisted addresses (undefined opcodes) act as NOP.
    always_comb begin
        w_ctrl = uword(C_FETCH1, 1'b0, 1'b0, 1'b0, 1'b0, C_B_PC, C_ALU_PASS, C_EN_NONE);
        case (r_upc_q)
            C_FETCH1: w_ctrl = uword(C_FETCH2, 1'b0, 1'b0, 1'b0, 1'b0, C_B_PC,  C_ALU_PASS, C_EN_AR);
            C_FETCH2: w_ctrl = uword(C_DECODE, 1'b0, 1'b0, 1'b1, 1'b0, C_B_MEM, C_ALU_PASS, C_EN_IR | C_EN_PCINC);
            C_DECODE: w_ctrl = uword(C_FETCH1, 1'b1, 1'b0, 1'b0, 1'b0, C_B_IR,  C_ALU_PASS, C_EN_NONE);
            C_MOV:    w_ctrl = uword(C_FETCH1, 1'b0, 1'b0, 1'b0, 1'b0, C_B_RS,  C_ALU_PASS, C_EN_RD);
            C_ADD1:   w_ctrl = uword(C_ADD2,   1'b0, 1'b0, 1'b0, 1'b0, C_B_RS,  C_ALU_ADD,  C_EN_AC);
            C_SUB1:   w_ctrl = uword(C_SUB2,   1'b0, 1'b0, 1'b0, 1'b0, C_B_RS,  C_ALU_SUB,  C_EN_AC);
            C_AND1:   w_ctrl = uword(C_AND2,   1'b0, 1'b0, 1'b0, 1'b0, C_B_RS,  C_ALU_AND,  C_EN_AC);
            C_OR1:    w_ctrl = uword(C_OR2,    1'b0, 1'b0, 1'b0, 1'b0, C_B_RS,  C_ALU_OR,   C_EN_AC);
            C_ADD2, C_SUB2, C_AND2, C_OR2:
                      w_ctrl = uword(C_FETCH1, 1'b0, 1'b0, 1'b0, 1'b0, C_B_AC,  C_ALU_PASS, C_EN_RD);
            C_LDI1:   w_ctrl = uword(C_LDI2,   1'b0, 1'b0, 1'b0, 1'b0, C_B_PC,  C_ALU_PASS, C_EN_AR);
            C_LDI2:   w_ctrl = uword(C_FETCH1, 1'b0, 1'b0, 1'b1, 1'b0, C_B_MEM, C_ALU_PASS, C_EN_RD | C_EN_PCINC);
            C_ST1:    w_ctrl = uword(C_ST2,    1'b0, 1'b0, 1'b0, 1'b0, C_B_RS,  C_ALU_PASS, C_EN_AR);
            C_ST2:    w_ctrl = uword(C_ST3,    1'b0, 1'b0, 1'b0, 1'b0, C_B_RD,  C_ALU_PASS, C_EN_DR);
            C_ST3:    w_ctrl = uword(C_FETCH1, 1'b0, 1'b0, 1'b0, 1'b1, C_B_DR,  C_ALU_PASS, C_EN_NONE);
            C_JMP:    w_ctrl = uword(C_FETCH1, 1'b0, 1'b0, 1'b0, 1'b0, C_B_RS,  C_ALU_PASS, C_EN_PC);
            // Taken branch lands on next_addr + 1.
            C_JZ1:    w_ctrl = uword(C_JZ_NO,  1'b0, 1'b1, 1'b0, 1'b0, C_B_AC,  C_ALU_PASS, C_EN_NONE);
            C_JZ_NO:  w_ctrl = uword(C_FETCH1, 1'b0, 1'b0, 1'b0, 1'b0, C_B_PC,  C_ALU_PASS, C_EN_NONE);
            C_JZ_YES: w_ctrl = uword(C_FETCH1, 1'b0, 1'b0, 1'b0, 1'b0, C_B_RS,  C_ALU_PASS, C_EN_PC);
            C_LD1:    w_ctrl = uword(C_LD2,    1'b0, 1'b0, 1'b0, 1'b0, C_B_RS,  C_ALU_PASS, C_EN_AR);
            C_LD2:    w_ctrl = uword(C_LD3,    1'b0, 1'b0, 1'b1, 1'b0, C_B_MEM, C_ALU_PASS, C_EN_DR);
            C_LD3:    w_ctrl = uword(C_FETCH1, 1'b0, 1'b0, 1'b0, 1'b0, C_B_DR,  C_ALU_PASS, C_EN_RD);
            C_HALT:   w_ctrl = uword(C_HALT,   1'b0, 1'b0, 1'b0, 1'b0, C_B_PC,  C_ALU_PASS, C_EN_NONE);
            default:  ;
        endcase
    end

    assign w_alu_a = r_regs_q[w_rd];
    assign w_stall = (w_mrd | w_mwr) & ~hit;

    always_comb begin
        case (w_bsel)
            C_B_PC:  w_b_bus = r_pc_q;
            C_B_AR:  w_b_bus = r_ar_q;
            C_B_DR:  w_b_bus = r_dr_q;
            C_B_IR:  w_b_bus = r_ir_q;
            C_B_AC:  w_b_bus = r_ac_q;
            C_B_RD:  w_b_bus = r_regs_q[w_rd];
            C_B_RS:  w_b_bus = r_regs_q[w_rs];
            C_B_MEM: w_b_bus = memory_in;
            default: w_b_bus = '0;
        endcase
    end

    always_comb begin
        case (w_aluop)
            C_ALU_ADD: w_c_bus = w_alu_a + w_b_bus;
            C_ALU_SUB: w_c_bus = w_alu_a - w_b_bus;
            C_ALU_AND: w_c_bus = w_alu_a & w_b_bus;
            C_ALU_OR:  w_c_bus = w_alu_a | w_b_bus;
            C_ALU_INC: w_c_bus = w_b_bus + 1'b1;
            default:   w_c_bus = w_b_bus;
        endcase
    end

    always_comb begin
        if (w_dbr) begin
            w_mux = {w_opcode, 3'b000};
        end else if (w_zbr && (r_ac_q == '0)) begin
            w_mux = w_next + 1'b1;
        end else begin
            w_mux = w_next;
        end
    end

    // A stalled access freezes the sequencer and suppresses every register write.
    always_comb begin
        w_upc_d  = w_stall ? r_upc_q : w_mux;
        w_pc_d   = r_pc_q;
        w_ar_d   = r_ar_q;
        w_dr_d   = r_dr_q;
        w_ir_d   = r_ir_q;
        w_ac_d   = r_ac_q;
        w_regs_d = r_regs_q;
        if (!w_stall) begin
            if (w_ctrl[0]) begin
                w_pc_d = w_c_bus;
            end else if (w_ctrl[6]) begin
                w_pc_d = r_pc_q + 1'b1;
            end
            if (w_ctrl[1]) w_ar_d = w_c_bus;
            if (w_ctrl[2]) w_dr_d = w_c_bus;
            if (w_ctrl[3]) w_ir_d = w_c_bus;
            if (w_ctrl[4]) w_ac_d = w_c_bus;
            if (w_ctrl[5]) w_regs_d[w_rd] = w_c_bus;
        end
    end

    always_ff @(posedge clk_100) begin
        if (rst) begin
            r_upc_q <= C_FETCH1;
            r_pc_q  <= '0;
            r_ar_q  <= '0;
            r_dr_q  <= '0;
            r_ir_q  <= '0;
            r_ac_q  <= '0;
            for (int i = 0; i < 16; i++) r_regs_q[i] <= '0;
        end else begin
            r_upc_q  <= w_upc_d;
            r_pc_q   <= w_pc_d;
            r_ar_q   <= w_ar_d;
            r_dr_q   <= w_dr_d;
            r_ir_q   <= w_ir_d;
            r_ac_q   <= w_ac_d;
            r_regs_q <= w_regs_d;
        end
    end

    assign memory_write_en = w_mwr;
    assign control_signals = w_ctrl;
    assign instruction     = r_ir_q;
    assign mux8            = w_mux;
    assign b_bus           = w_b_bus;
    assign c_bus           = w_c_bus;
    assign acc             = r_ac_q;
    assign tester          = r_regs_q[w_rd];
    assign address_out     = r_ar_q;
    assign memory_out      = r_dr_q;

endmodule
`default_nettype wire

// File: tb/tb_u_processor.sv
`default_nettype none
// ============================================================================
// Module   : tb_u_processor
// Brief    : Bench for u_processor: instruction-level reference model checked
//            against every completed memory access, plus directed programs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_u_processor;

    logic        clk_100 = 1'b0;
    logic        rst, hit;
    logic [15:0] memory_in;
    logic        memory_write_en;
    logic [38:0] control_signals;
    logic [15:0] instruction, b_bus, c_bus, acc, tester, address_out, memory_out;
    logic [7:0]  mux8;

    always #5 clk_100 = ~clk_100;

    u_processor dut (
        .clk_100         (clk_100),
        .rst             (rst),
        .memory_in       (memory_in),
        .hit             (hit),
        .memory_write_en (memory_write_en),
        .control_signals (control_signals),
        .instruction     (instruction),
        .mux8            (mux8),
        .b_bus           (b_bus),
        .c_bus           (c_bus),
        .acc             (acc),
        .tester          (tester),
        .address_out     (address_out),
        .memory_out      (memory_out)
    );

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        bit          fetch;
        logic [15:0] acc;
        logic [15:0] tester;
    } access_t;

    int checks = 0;
    int errors = 0;

    logic [15:0] bus_mem   [0:65535];
    logic [15:0] model_mem [0:65535];
    logic [15:0] m_regs [16];
    logic [15:0] m_pc, m_acc;
    bit          m_halted;
    int          m_icount;
    access_t     exp_q [$];
    bit          pend_ir;
    access_t     pend_rec;

    int hit_pct = 100;
    int hold_hit = 0;
    bit hold_we_forever = 0;
    bit stall_store = 0;
    bit we_seen = 0;
    int we_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Architectural model: one whole instruction per call, recording the
    // memory transactions it must produce in order.
    function automatic void model_step();
        logic [15:0] ins, v;
        logic [3:0]  d, s;
        if (m_halted) return;
        ins = model_mem[m_pc];
        d = ins[7:4];
        s = ins[3:0];
        exp_q.push_back('{1'b0, m_pc, ins, 1'b1, m_acc, m_regs[d]});
        m_pc = m_pc + 16'd1;
        m_icount++;
        case (ins[15:11])
            5'h01: m_regs[d] = m_regs[s];
            5'h02: begin m_acc = m_regs[d] + m_regs[s]; m_regs[d] = m_acc; end
            5'h03: begin m_acc = m_regs[d] - m_regs[s]; m_regs[d] = m_acc; end
            5'h04: begin m_acc = m_regs[d] & m_regs[s]; m_regs[d] = m_acc; end
            5'h05: begin m_acc = m_regs[d] | m_regs[s]; m_regs[d] = m_acc; end
            5'h06: begin
                v = model_mem[m_pc];
                exp_q.push_back('{1'b0, m_pc, v, 1'b0, 16'h0, 16'h0});
                m_regs[d] = v;
                m_pc = m_pc + 16'd1;
            end
            5'h07: begin
                exp_q.push_back('{1'b1, m_regs[s], m_regs[d], 1'b0, 16'h0, 16'h0});
                model_mem[m_regs[s]] = m_regs[d];
            end
            5'h08: m_pc = m_regs[s];
            5'h09: if (m_acc == 16'h0) m_pc = m_regs[s];
            5'h1C: begin
                v = model_mem[m_regs[s]];
                exp_q.push_back('{1'b0, m_regs[s], v, 1'b0, 16'h0, 16'h0});
                m_regs[d] = v;
            end
            5'h1F: m_halted = 1'b1;
            default: ;
        endcase
    endfunction

    task automatic observe();
        access_t r;
        if (exp_q.size() == 0) model_step();
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL access_after_halt: got access at 0x%0h, expected none", address_out);
            return;
        end
        r = exp_q.pop_front();
        check("access_kind", 32'(control_signals[27]), 32'(r.wr));
        check("access_addr", 32'(address_out), 32'(r.addr));
        if (r.wr) begin
            check("write_data", 32'(memory_out), 32'(r.data));
            bus_mem[address_out] = memory_out;
        end else begin
            check("read_data", 32'(memory_in), 32'(r.data));
        end
        if (r.fetch) begin
            check("acc_at_fetch", 32'(acc), 32'(r.acc));
            pend_ir  = 1'b1;
            pend_rec = r;
        end
    endtask

    // One clock: check, respond as memory, decide hit, then see whether the
    // coming edge completes an access.
    task automatic cycle();
        @(negedge clk_100);
        if (rst) pend_ir = 1'b0;
        if (pend_ir) begin
            pend_ir = 1'b0;
            check("instruction", 32'(instruction), 32'(pend_rec.data));
            check("tester", 32'(tester), 32'(pend_rec.tester));
        end
        memory_in = bus_mem[address_out];
        if (memory_write_en) we_cycles++;
        if (hold_hit > 0) begin
            hit = 1'b0;
            hold_hit--;
        end else if (hold_we_forever && memory_write_en) begin
            hit = 1'b0;
        end else if (stall_store && memory_write_en) begin
            if (!we_seen) begin
                we_seen  = 1'b1;
                hold_hit = 2;
                hit      = 1'b0;
            end else begin
                hit = 1'b1;
            end
        end else begin
            hit = ($urandom_range(99) < hit_pct);
        end
        #1;
        if (!rst && hit && (control_signals[28] || control_signals[27])) observe();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        m_pc = 16'h0;
        m_acc = 16'h0;
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
        m_halted = 1'b0;
        m_icount = 0;
        exp_q.delete();
        pend_ir = 1'b0;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 65536; i++) begin
            bus_mem[i]   = 16'hF800;
            model_mem[i] = 16'hF800;
        end
    endtask

    task automatic put(input int a, input logic [15:0] w);
        bus_mem[a]   = w;
        model_mem[a] = w;
    endtask

    task automatic load_p1();
        fill_mem();
        put(0, 16'h3010); put(1, 16'hFFFF);
        put(2, 16'h3020); put(3, 16'h0002);
        put(4, 16'h1012);
        put(5, 16'h3050); put(6, 16'h1234);
        put(7, 16'h3040); put(8, 16'h0040);
        put(9, 16'h3854);
        put(10, 16'hE064);
        put(11, 16'hF860);
    endtask

    task automatic gen_prog();
        int n;
        logic [15:0] w;
        logic [4:0] op;
        fill_mem();
        n = 0;
        while (n < 60) begin
            case ($urandom_range(15))
                0: op = 5'h00;  1: op = 5'h01;  2: op = 5'h02;  3: op = 5'h03;
                4: op = 5'h04;  5: op = 5'h05;  6, 7: op = 5'h06;  8: op = 5'h07;
                9: op = 5'h08; 10: op = 5'h09; 11, 12: op = 5'h1C; 13: op = 5'h0B;
                14: op = 5'h15;
                default: op = ($urandom_range(3) == 0) ? 5'h1F : 5'h06;
            endcase
            w = 16'($urandom);
            w[15:11] = op;
            put(n, w);
            n++;
            if (op == 5'h06) begin
                w = 16'($urandom);
                if ($urandom_range(1) == 0) w = {10'h0, w[5:0]};
                put(n, w);
                n++;
            end
        end
    endtask

    task automatic run_prog(input int max_instr);
        int quiet = 0;
        int cyc = 0;
        while (1) begin
            cycle();
            cyc++;
            if (m_halted && exp_q.size() == 0 && !pend_ir) quiet++;
            if (quiet >= 25) begin
                check("halt_selfloop", 32'(mux8), 32'h0000_00F8);
                break;
            end
            if (!m_halted && m_icount >= max_instr && exp_q.size() == 0 && !pend_ir) break;
            if (cyc >= 4000) begin
                checks++;
                errors++;
                $display("FAIL run_timeout: got %0d cycles, expected halt or %0d instructions", cyc, max_instr);
                break;
            end
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        hit = 1'b0;
        memory_in = 16'h0;

        // Directed program: fetch stall, LDI, ADD wrap, delayed STORE, LOAD, END.
        load_p1();
        do_reset();
        check("rst_acc", 32'(acc), 32'h0);
        check("rst_instruction", 32'(instruction), 32'h0);
        check("rst_address_out", 32'(address_out), 32'h0);
        check("rst_memory_out", 32'(memory_out), 32'h0);
        check("rst_tester", 32'(tester), 32'h0);
        check("rst_b_bus", 32'(b_bus), 32'h0);
        check("rst_c_bus", 32'(c_bus), 32'h0);
        check("rst_mux8", 32'(mux8), 32'h1);
        check("rst_we", 32'(memory_write_en), 32'h0);
        hit_pct = 100;
        stall_store = 1'b1;
        we_seen = 1'b0;
        we_cycles = 0;
        hold_hit = 5;
        repeat (5) cycle();
        check("stall_instruction", 32'(instruction), 32'h0);
        check("stall_mux8", 32'(mux8), 32'h2);
        run_prog(100);
        check("p1_acc", 32'(acc), 32'h0001);
        check("p1_tester", 32'(tester), 32'h1234);
        check("p1_instruction", 32'(instruction), 32'hF860);
        check("p1_address_out", 32'(address_out), 32'h000B);
        check("p1_memory_out", 32'(memory_out), 32'h1234);
        check("p1_stored_word", 32'(bus_mem[16'h0040]), 32'h1234);
        check("p1_we_cycles", 32'(we_cycles), 32'd4);
        stall_store = 1'b0;

        // Reset while a store is waiting for hit.
        load_p1();
        do_reset();
        hold_we_forever = 1'b1;
        n = 0;
        while (!memory_write_en && n < 300) begin
            cycle();
            n++;
        end
        check("abort_store_reached", 32'(memory_write_en), 32'h1);
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        check("abort_we", 32'(memory_write_en), 32'h0);
        check("abort_mux8", 32'(mux8), 32'h1);
        check("abort_address_out", 32'(address_out), 32'h0);
        check("abort_acc", 32'(acc), 32'h0);
        hold_we_forever = 1'b0;
        rst = 1'b0;

        // Random programs with random memory latency.
        hit_pct = 60;
        for (int r = 0; r < 10; r++) begin
            gen_prog();
            do_reset();
            run_prog(120);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/u_processor.md
Name: u_processor

Overview:
- 16-bit microprogrammed accumulator/register processor with an external single-port memory interface, clocked from the 100 MHz board clock.
- A 256-entry microcode ROM produces a 39-bit control word each cycle; datapath registers exchange data over a B bus (source) and a C bus (ALU result/write-back).
- Internal state is exported for debug and bring-up: control word, current instruction, micro-address mux, buses, accumulator and a register readback.

Parameters:
- DATA_W, 16, datapath, instruction and memory word width.
- UADDR_W, 8, micro-address width (ROM depth 2^UADDR_W).
- CTRL_W, 39, microinstruction width.

Ports:
- clk_100 in 1: sole clock; all state updates on its rising edge.
- rst in 1: synchronous, active-high reset.
- memory_in in 16: read data from memory; sampled only when hit=1 during a read micro-state.
- hit in 1: memory ready; the current read/write access completes on a cycle with hit=1.
- memory_write_en out 1: write strobe; high in store micro-state.
- control_signals out 39: current microinstruction.
- instruction out 16: IR contents.
- mux8 out 8: next micro-address selected this cycle.
- b_bus out 16: value on the B bus.
- c_bus out 16: value on the C bus (ALU output).
- acc out 16: AC register.
- tester out 16: R[IR[7:4]] (destination register readback).
- address_out out 16: AR register.
- memory_out out 16: DR register (write data).

Behaviour:
- Reset (rst=1 at clk edge): PC, AR, DR, IR, AC, R0..R15 <= 0; uPC <= 0 (FETCH1); memory_write_en=0; all outputs derived from these registers read 0.
- Instruction format: [15:11] opcode, [10:8] ignored, [7:4] rd, [3:0] rs. Sixteen 16-bit general registers.
- Control word: [38:31] next_addr, [30] decode_branch, [29] zero_branch, [28] mem_rd, [27] mem_wr, [26:23] b_sel, [22:20] alu_op (PASS, ADD, SUB, AND, OR, INC), [19:0] one-hot C-bus write enables (PC, AR, DR, IR, AC, Rd) and misc.
- mux8: decode_branch ? opcode dispatch address : zero_branch&&AC==0 ? branch target : next_addr.
- Memory stall: in any state with mem_rd or mem_wr, uPC holds and no register is written while hit=0. When hit=1, the access completes and the sequencer advances.
- Fetch sequence:
  - FETCH1: AR<=PC (1 cycle).
  - FETCH2 (mem_rd): IR<=memory_in, PC<=PC+1.
  - DECODE: dispatch on opcode (1 cycle).
- Opcodes; every execute sequence returns to FETCH1:
  - 00000 NOP.
  - 00001 MOV: R[rd]<=R[rs].
  - 00010 ADD, 00011 SUB, 00100 AND, 00101 OR: AC<=R[rd] op R[rs]; R[rd]<=AC next cycle. Arithmetic is 16-bit modulo 2^16; carry/borrow is discarded.
  - 00110 LDI: AR<=PC; read; R[rd]<=memory_in; PC<=PC+1.
  - 00111 STORE: AR<=R[rs], DR<=R[rd]; then memory_write_en=1 until hit.
  - 01000 JMP: PC<=R[rs].
  - 01001 JZ: PC<=R[rs] if AC==0.
  - 11100 LOAD: AR<=R[rs]; read (DR<=memory_in); R[rd]<=DR.
  - 11111 END: enter HALT; uPC self-loops and no state changes until rst.
  - All other opcodes: NOP.
- Boundary conditions:
  - PC wraps 0xFFFF->0x0000.
  - rd==rs is legal and uses pre-edge values.
  - rst has priority over a pending access; the in-flight access is aborted and memory_write_en drops on the reset edge.
  - hit=1 outside an access state is ignored.

Test Plan:
- Reset: assert rst 2 cycles -> all outputs 0; mux8 shows FETCH1 successor; memory_write_en=0.
- Fetch stall: memory_in=0xE063 (LOAD r6,r3), hit=0 for 5 cycles -> uPC frozen in FETCH2, IR stays 0. Raise hit -> IR=0xE063, PC=1.
- LOAD: R3=0 from reset, instruction 0xE063, data word 15 at address 0 with hit=1 -> address_out=0, tester (R6)=15 after the execute sequence.
- ADD wrap: LDI r1=0xFFFF, LDI r2=2, ADD r1,r2 -> acc=0x0001, tester=0x0001.
- STORE: R5=0x1234, R4=0x0040, STORE r5,r4 with hit delayed 3 cycles -> address_out=0x0040, memory_out=0x1234, memory_write_en high exactly until the hit cycle.
- END: memory_in=0xF800 -> processor halts, PC constant for 20 cycles; rst returns it to FETCH1 with PC=0.
